// File: rtl/fifo_flags.sv
// Synchronous single-clock FIFO with occupancy counter, programmable
// almost-full / almost-empty thresholds and sticky overflow / underflow flags.
// FWFT selects between a registered read port and first-word-fall-through.
module fifo_flags #(
   parameter int FIFO_WIDTH = 63,
   parameter int FIFO_DEPTH = 8,
   parameter int FWFT       = 0,
   parameter int FIFO_BITS  = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  write_n,
   input  logic                  read_n,
   input  logic [FIFO_BITS:0]    af_thresh,
   input  logic [FIFO_BITS:0]    ae_thresh,
   input  logic                  clear_errors,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic [FIFO_BITS:0]    fifo_counter,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic                  fifo_almost_full,
   output logic                  fifo_almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   // Count value meaning "every word occupied", and the last legal pointer
   // value before wrapping (depth need not be a power of two).
   localparam logic [FIFO_BITS:0]   DEPTH_CNT = (FIFO_BITS+1)'(FIFO_DEPTH);
   localparam logic [FIFO_BITS-1:0] LAST_PTR  = FIFO_BITS'(FIFO_DEPTH-1);

   logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [FIFO_BITS-1:0]  r_wr_ptr;
   logic [FIFO_BITS-1:0]  r_rd_ptr;
   logic [FIFO_BITS:0]    r_count;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_rd_accept;
   logic                  w_wr_accept;
   logic [FIFO_WIDTH-1:0] w_head_word;

   // A read needs a stored word; a write needs a free slot, or a slot being
   // freed by a read in the same cycle (so a full FIFO can stream).
   assign w_rd_accept = !read_n && (r_count != '0);
   assign w_wr_accept = !write_n && ((r_count != DEPTH_CNT) || w_rd_accept);
   assign w_head_word = r_mem[r_rd_ptr];

   // Pointer and occupancy tracking; rejected accesses leave all of it alone.
   // NOTE: sequential state uses non-blocking assignment so every register
   // samples pre-edge values, independent of block or statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_accept) begin
            r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_rd_accept) begin
            r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({w_wr_accept, w_rd_accept})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array, written only on an accepted write.
   // NOTE: the memory is deliberately not reset; contents are meaningless
   // until written, and the empty count already hides stale words.
   always_ff @(posedge clk) begin
      if (w_wr_accept) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   // Sticky error flags: a new error in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (!write_n && !w_wr_accept) begin
            r_overflow <= 1'b1;
         end else if (clear_errors) begin
            r_overflow <= 1'b0;
         end
         if (!read_n && !w_rd_accept) begin
            r_underflow <= 1'b1;
         end else if (clear_errors) begin
            r_underflow <= 1'b0;
         end
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is always presented; a read consumes what is shown.
         assign data_out   = w_head_word;
         assign data_valid = (r_count != '0);
      end else begin : g_registered
         logic [FIFO_WIDTH-1:0] r_data_out;
         logic                  r_data_valid;

         // Registered read port: load the head word on an accepted read and
         // hold it otherwise; valid marks only the cycle after the pop.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_data_out   <= '0;
               r_data_valid <= 1'b0;
            end else begin
               r_data_valid <= w_rd_accept;
               if (w_rd_accept) begin
                  r_data_out <= w_head_word;
               end
            end
         end

         assign data_out   = r_data_out;
         assign data_valid = r_data_valid;
      end
   endgenerate

   // Status flags are plain decodes of the registered count.
   assign fifo_counter      = r_count;
   assign fifo_full         = (r_count == DEPTH_CNT);
   assign fifo_empty        = (r_count == '0);
   assign fifo_almost_full  = (r_count >= af_thresh);
   assign fifo_almost_empty = (r_count <= ae_thresh);
   assign overflow          = r_overflow;
   assign underflow         = r_underflow;

endmodule

// File: tb/tb_fifo_flags.sv
// Bench for fifo_flags: three instances (depth 8 registered read, depth 5
// registered read, depth 8 FWFT) share one input stream. A queue-based model
// of each FIFO is compared against every instance on each falling edge, and
// directed literal expectations pin the model at the interesting points.
module tb_fifo_flags;

   localparam int W = 63;
   localparam int N = 3;

   int depth_of [N] = '{8, 5, 8};
   bit fwft_of  [N] = '{1'b0, 1'b0, 1'b1};

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [W-1:0] data_in = '0;
   logic         write_n = 1'b1;
   logic         read_n = 1'b1;
   logic         clear_errors = 1'b0;
   logic [3:0]   af_thresh = 4'd0;
   logic [3:0]   ae_thresh = 4'd0;

   logic [W-1:0] dout   [N];
   logic         dvalid [N];
   logic [3:0]   cnt    [N];
   logic         full   [N];
   logic         empty  [N];
   logic         afull  [N];
   logic         aempty [N];
   logic         ovf    [N];
   logic         udf    [N];

   fifo_flags #(.FIFO_WIDTH(W), .FIFO_DEPTH(8), .FWFT(0)) u0 (
      .clk(clk), .reset_n(reset_n), .data_in(data_in), .write_n(write_n),
      .read_n(read_n), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .clear_errors(clear_errors), .data_out(dout[0]), .data_valid(dvalid[0]),
      .fifo_counter(cnt[0]), .fifo_full(full[0]), .fifo_empty(empty[0]),
      .fifo_almost_full(afull[0]), .fifo_almost_empty(aempty[0]),
      .overflow(ovf[0]), .underflow(udf[0]));

   fifo_flags #(.FIFO_WIDTH(W), .FIFO_DEPTH(5), .FWFT(0)) u1 (
      .clk(clk), .reset_n(reset_n), .data_in(data_in), .write_n(write_n),
      .read_n(read_n), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .clear_errors(clear_errors), .data_out(dout[1]), .data_valid(dvalid[1]),
      .fifo_counter(cnt[1]), .fifo_full(full[1]), .fifo_empty(empty[1]),
      .fifo_almost_full(afull[1]), .fifo_almost_empty(aempty[1]),
      .overflow(ovf[1]), .underflow(udf[1]));

   fifo_flags #(.FIFO_WIDTH(W), .FIFO_DEPTH(8), .FWFT(1)) u2 (
      .clk(clk), .reset_n(reset_n), .data_in(data_in), .write_n(write_n),
      .read_n(read_n), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .clear_errors(clear_errors), .data_out(dout[2]), .data_valid(dvalid[2]),
      .fifo_counter(cnt[2]), .fifo_full(full[2]), .fifo_empty(empty[2]),
      .fifo_almost_full(afull[2]), .fifo_almost_empty(aempty[2]),
      .overflow(ovf[2]), .underflow(udf[2]));

   always #5 clk = ~clk;

   // ---------------- model: a queue per FIFO ----------------
   logic [W-1:0] mq     [N][$];
   logic [W-1:0] m_dout [N];
   bit           m_dv   [N];
   bit           m_ovf  [N];
   bit           m_udf  [N];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         mq[k].delete();
         m_dout[k] = '0;
         m_dv[k]   = 1'b0;
         m_ovf[k]  = 1'b0;
         m_udf[k]  = 1'b0;
      end
   endtask

   // One clock edge of every FIFO, from the access rules alone.
   task automatic model_edge();
      int           sz;
      bit           rd;
      bit           wr;
      logic [W-1:0] word;
      for (int k = 0; k < N; k++) begin
         sz = mq[k].size();
         rd = !read_n && (sz != 0);
         wr = !write_n && ((sz != depth_of[k]) || rd);
         if (!write_n && !wr) m_ovf[k] = 1'b1;
         else if (clear_errors) m_ovf[k] = 1'b0;
         if (!read_n && !rd) m_udf[k] = 1'b1;
         else if (clear_errors) m_udf[k] = 1'b0;
         if (!fwft_of[k]) m_dv[k] = rd;
         if (rd) begin
            word = mq[k].pop_front();
            if (!fwft_of[k]) m_dout[k] = word;
         end
         if (wr) mq[k].push_back(data_in);
      end
   endtask

   task automatic compare_all();
      int sz;
      for (int k = 0; k < N; k++) begin
         sz = mq[k].size();
         check($sformatf("u%0d.count", k), 64'(cnt[k]), 64'(sz));
         check($sformatf("u%0d.full", k), 64'(full[k]), 64'(sz == depth_of[k]));
         check($sformatf("u%0d.empty", k), 64'(empty[k]), 64'(sz == 0));
         check($sformatf("u%0d.almost_full", k), 64'(afull[k]), 64'(sz >= int'(af_thresh)));
         check($sformatf("u%0d.almost_empty", k), 64'(aempty[k]), 64'(sz <= int'(ae_thresh)));
         check($sformatf("u%0d.overflow", k), 64'(ovf[k]), 64'(m_ovf[k]));
         check($sformatf("u%0d.underflow", k), 64'(udf[k]), 64'(m_udf[k]));
         if (fwft_of[k]) begin
            check($sformatf("u%0d.data_valid", k), 64'(dvalid[k]), 64'(sz != 0));
            if (sz != 0) check($sformatf("u%0d.data_out", k), 64'(dout[k]), 64'(mq[k][0]));
         end else begin
            check($sformatf("u%0d.data_valid", k), 64'(dvalid[k]), 64'(m_dv[k]));
            check($sformatf("u%0d.data_out", k), 64'(dout[k]), 64'(m_dout[k]));
         end
      end
   endtask

   // Outputs settle after the rising edge; compare them on the falling edge.
   always @(negedge clk) compare_all();

   // ---------------- stimulus helpers ----------------
   task automatic cycle(input bit w, input logic [W-1:0] d, input bit r, input bit clr);
      write_n      = !w;
      read_n       = !r;
      data_in      = d;
      clear_errors = clr;
      @(posedge clk);
      model_edge();
      #1;
      write_n      = 1'b1;
      read_n       = 1'b1;
      clear_errors = 1'b0;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   // Mixed wrap sequence on the depth-5 FIFO: write word or expected read word.
   bit         tbl_w   [12] = '{1,1,1,1,0,1,1,1,0,0,0,0};
   logic [7:0] tbl_d   [12] = '{8'hA0,8'hA1,8'hA2,8'hA3,8'hA0,8'hA4,
                                8'hA5,8'hA6,8'hA1,8'hA2,8'hA3,8'hA4};
   int         tbl_c1  [12] = '{1,2,3,4,3,4,5,5,4,3,2,1};
   int         tbl_c0  [12] = '{1,2,3,4,3,4,5,6,5,4,3,2};

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      // Reset state with af_thresh = 0: almost_full reads 1 while empty.
      repeat (2) @(posedge clk);
      #1;
      check("rst.empty", 64'(empty[0]), 64'd1);
      check("rst.full", 64'(full[0]), 64'd0);
      check("rst.almost_empty", 64'(aempty[0]), 64'd1);
      check("rst.almost_full_af0", 64'(afull[0]), 64'd1);
      check("rst.data_out", 64'(dout[0]), 64'd0);
      reset_n = 1'b1;
      af_thresh = 4'd6;
      ae_thresh = 4'd2;
      #1;
      check("rst.almost_full_af6", 64'(afull[0]), 64'd0);

      // Fill with 1..8; thresholds toggle at count 6 and count 2.
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b1, W'(i), 1'b0, 1'b0);
         check($sformatf("fill%0d.almost_full", i), 64'(afull[0]), 64'(i >= 6));
         check($sformatf("fill%0d.almost_empty", i), 64'(aempty[0]), 64'(i <= 2));
         if (i == 1) begin
            check("fwft.first_data_out", 64'(dout[2]), 64'd1);
            check("fwft.first_valid", 64'(dvalid[2]), 64'd1);
         end
      end
      check("fill.count", 64'(cnt[0]), 64'd8);
      check("fill.full", 64'(full[0]), 64'd1);
      check("d5.fill.count", 64'(cnt[1]), 64'd5);
      check("d5.fill.overflow", 64'(ovf[1]), 64'd1);

      // Overflow at full, then clear.
      cycle(1'b1, W'('hAA), 1'b0, 1'b0);
      check("ovf.set", 64'(ovf[0]), 64'd1);
      check("ovf.count", 64'(cnt[0]), 64'd8);
      cycle(1'b0, '0, 1'b0, 1'b1);
      check("ovf.cleared", 64'(ovf[0]), 64'd0);

      // Drain: each word valid in the cycle after its read.
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b0);
         check($sformatf("drain%0d.data_out", i), 64'(dout[0]), 64'(i));
         check($sformatf("drain%0d.valid", i), 64'(dvalid[0]), 64'd1);
      end
      cycle(1'b0, '0, 1'b0, 1'b1);
      check("drain.empty", 64'(empty[0]), 64'd1);
      check("drain.valid_drops", 64'(dvalid[0]), 64'd0);
      check("drain.data_hold", 64'(dout[0]), 64'd8);

      // Simultaneous read and write at full.
      for (int i = 0; i < 8; i++) cycle(1'b1, W'('h11 + i), 1'b0, 1'b0);
      cycle(1'b1, W'('h55), 1'b1, 1'b0);
      check("full_rw.count", 64'(cnt[0]), 64'd8);
      check("full_rw.no_overflow", 64'(ovf[0]), 64'd0);
      check("full_rw.data_out", 64'(dout[0]), 64'h11);
      for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
      check("full_rw.last_word", 64'(dout[0]), 64'h55);
      check("full_rw.empty", 64'(empty[0]), 64'd1);
      cycle(1'b0, '0, 1'b0, 1'b1);

      // Simultaneous read and write at empty.
      cycle(1'b1, W'('h33), 1'b1, 1'b0);
      check("empty_rw.underflow", 64'(udf[0]), 64'd1);
      check("empty_rw.count", 64'(cnt[0]), 64'd1);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("empty_rw.read", 64'(dout[0]), 64'h33);
      cycle(1'b0, '0, 1'b0, 1'b1);

      // Mixed writes/reads: pointer wrap on depth 5, thresholds on depth 8.
      for (int j = 0; j < 12; j++) begin
         cycle(tbl_w[j], W'(tbl_d[j]), !tbl_w[j], 1'b0);
         check($sformatf("wrap%0d.d5.count", j), 64'(cnt[1]), 64'(tbl_c1[j]));
         check($sformatf("wrap%0d.d8.count", j), 64'(cnt[0]), 64'(tbl_c0[j]));
         if (!tbl_w[j]) begin
            check($sformatf("wrap%0d.d5.data", j), 64'(dout[1]), 64'(tbl_d[j]));
            check($sformatf("wrap%0d.d8.data", j), 64'(dout[0]), 64'(tbl_d[j]));
         end
      end
      check("wrap.d5.overflow", 64'(ovf[1]), 64'd1);
      check("wrap.d8.almost_empty", 64'(aempty[0]), 64'd1);
      cycle(1'b0, '0, 1'b0, 1'b1);

      // FWFT presentation and asynchronous reset mid-operation.
      apply_reset();
      cycle(1'b1, W'('h7), 1'b0, 1'b0);
      check("fwft.data_out", 64'(dout[2]), 64'h7);
      check("fwft.valid", 64'(dvalid[2]), 64'd1);
      cycle(1'b1, W'('h8), 1'b0, 1'b0);
      cycle(1'b1, W'('h9), 1'b0, 1'b0);
      check("fwft.count3", 64'(cnt[2]), 64'd3);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check("async.count", 64'(cnt[2]), 64'd0);
      check("async.valid", 64'(dvalid[2]), 64'd0);
      check("async.empty", 64'(empty[2]), 64'd1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("post_rst.underflow_d8", 64'(udf[0]), 64'd1);
      check("post_rst.underflow_fwft", 64'(udf[2]), 64'd1);
      repeat (2) @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
